// File: rtl/fetch_sequencer_if.sv
// Bundle of the instruction-memory, redirect and decode-side signals of the
// fetch sequencer. The sequencer connects via the master modport; the memory,
// execute and decode side connects via the slave modport.
interface fetch_sequencer_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_target,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_target,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a synchronous instruction memory.
// Issues sequential word fetches, tracks the single read in flight, and
// buffers returned words in a 2-entry shift queue drained by decode with
// valid/ready. Redirects flush the queue and the in-flight read.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam logic [15:0] START_PC = RESET_PC & 16'hFFFE;

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       fetch_pc_r;
  logic [15:0]       fetch_pc_s;
  logic              inflight_v_r;
  logic [15:0]       inflight_pc_r;

  // Queue slot 0 is the head; slot 1 is only valid while slot 0 is valid.
  logic [1:0]        q_v_r;
  logic [1:0][15:0]  q_data_r;
  logic [1:0][15:0]  q_pc_r;
  logic [1:0]        q_v_s;
  logic [1:0][15:0]  q_data_s;
  logic [1:0][15:0]  q_pc_s;

  // Queue contents after the pop, before the push.
  logic [1:0]        a_v_s;
  logic [1:0][15:0]  a_data_s;
  logic [1:0][15:0]  a_pc_s;

  logic              redirect_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [1:0]        count_s;
  logic [2:0]        occ_s;
  logic              overflow_s;

  assign redirect_s = bus.redirect_valid;
  assign pop_s      = q_v_r[0] & bus.instr_ready;
  assign count_s    = {1'b0, q_v_r[0]} + {1'b0, q_v_r[1]};
  // Slots that will be committed after this edge: queued + in flight - popped.
  assign occ_s      = {1'b0, count_s} + {2'b00, inflight_v_r} - {2'b00, pop_s};
  assign issue_s    = (state_r == FETCH) & ~redirect_s & (occ_s < 3'd2);
  assign push_s     = inflight_v_r & ~redirect_s;
  assign overflow_s = push_s & (count_s == 2'd2) & ~pop_s;

  // Outputs come straight from registers.
  assign bus.imem_addr   = fetch_pc_r;
  assign bus.instr_valid = q_v_r[0];
  assign bus.instr_data  = q_data_r[0];
  assign bus.instr_pc    = q_pc_r[0];

  // Next-state logic: fetch only while run is high; redirects leave state alone.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) state_s = FETCH;
        else     state_s = IDLE;
      end
      FETCH: begin
        if (!run) state_s = IDLE;
        else      state_s = FETCH;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next fetch address: redirect target wins, else advance on issue, else hold.
  always_comb begin
    fetch_pc_s = fetch_pc_r;
    if (redirect_s)   fetch_pc_s = bus.redirect_target & 16'hFFFE;
    else if (issue_s) fetch_pc_s = fetch_pc_r + PC_STEP;
    else              fetch_pc_s = fetch_pc_r;
  end

  // Pop stage: shift slot 1 into the head; an emptied head keeps its data.
  always_comb begin
    a_v_s    = q_v_r;
    a_data_s = q_data_r;
    a_pc_s   = q_pc_r;
    if (pop_s && q_v_r[1]) begin
      a_v_s       = 2'b01;
      a_data_s[0] = q_data_r[1];
      a_pc_s[0]   = q_pc_r[1];
    end else if (pop_s) begin
      a_v_s = 2'b00;
    end else begin
      a_v_s = q_v_r;
    end
  end

  // Push/flush stage: a redirect empties the queue, otherwise append the return.
  always_comb begin
    q_v_s    = a_v_s;
    q_data_s = a_data_s;
    q_pc_s   = a_pc_s;
    if (redirect_s) begin
      q_v_s = 2'b00;
    end else if (push_s) begin
      if (!a_v_s[0]) begin
        q_v_s[0]    = 1'b1;
        q_data_s[0] = bus.imem_rdata;
        q_pc_s[0]   = inflight_pc_r;
      end else begin
        q_v_s[1]    = 1'b1;
        q_data_s[1] = bus.imem_rdata;
        q_pc_s[1]   = inflight_pc_r;
      end
    end else begin
      q_v_s = a_v_s;
    end
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      fetch_pc_r <= START_PC;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
    end
  end

  // In-flight read tracker: set only by an issue, cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_v_r  <= 1'b0;
      inflight_pc_r <= 16'h0000;
    end else begin
      inflight_v_r  <= issue_s;
      inflight_pc_r <= issue_s ? fetch_pc_r : inflight_pc_r;
    end
  end

  // Instruction queue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_v_r    <= 2'b00;
      q_data_r <= '0;
      q_pc_r   <= '0;
    end else begin
      q_v_r    <= q_v_s;
      q_data_r <= q_data_s;
      q_pc_r   <= q_pc_s;
    end
  end

  fetch_sequencer_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .overflow   (overflow_s),
    .head_valid (q_v_r[0]),
    .head_ready (bus.instr_ready),
    .redirect   (redirect_s),
    .head_data  (q_data_r[0]),
    .head_pc    (q_pc_r[0])
  );

endmodule

// Protocol checks for the fetch queue.
module fetch_sequencer_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        overflow,
  input logic        head_valid,
  input logic        head_ready,
  input logic        redirect,
  input logic [15:0] head_data,
  input logic [15:0] head_pc
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (head_valid && !head_ready && !redirect) |=> ($stable(head_data) && $stable(head_pc)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table covers startup,
// back-pressure, redirect and run/stop; hand sequences cover the async reset
// mid-stream and the PC wrap of a second instance started near 16'hFFFF.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic run0;
  logic run1;

  fetch_sequencer_if if0 ();
  fetch_sequencer_if if1 ();

  fetch_sequencer #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .bus(if0)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFC), .PC_STEP(16'd2)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .bus(if1)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000)      return 16'h3111;
    else if (a == 16'h0002) return 16'h3222;
    else                    return a ^ 16'hA5A5;
  endfunction

  // Synchronous instruction memories: word for the address of the previous cycle.
  always @(posedge clk) begin
    if0.imem_rdata <= mem_word(if0.imem_addr);
    if1.imem_rdata <= mem_word(if1.imem_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        run;
    logic        ready;
    logic        redir;
    logic [15:0] target;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_data;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[24];

  // rst_hd=1: head still holds its reset contents (pc 0, data 0).
  function automatic vec_t mk(input logic run, input logic ready, input logic redir,
                              input logic [15:0] target, input logic valid,
                              input logic [15:0] pc, input logic [15:0] addr,
                              input logic rst_hd);
    vec_t v;
    v.run       = run;
    v.ready     = ready;
    v.redir     = redir;
    v.target    = target;
    v.exp_valid = valid;
    v.exp_pc    = pc;
    v.exp_data  = rst_hd ? 16'h0000 : mem_word(pc);
    v.exp_addr  = addr;
    return v;
  endfunction

  initial begin
    // startup, ready=1: first issue in cycle 1, first valid in cycle 3
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b1);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0004, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0006, 1'b0);
    // ready low 5 cycles: queue fills to 2, issue stops, head holds
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0008, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h000A, 1'b0);
    // redirect to odd target with head queued and read of 0x000A in flight
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 16'h0009, 1'b1, 16'h0008, 16'h000C, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h0008, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h000A, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h000C, 1'b0);
    // run drops: the read issued in the last FETCH cycle still lands
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'h000E, 1'b0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 16'h0010, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000E, 16'h0010, 1'b0);
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000E, 16'h0010, 1'b0);
    // run returns: resume at the next sequential PC 0x0010
    vecs[20] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000E, 16'h0010, 1'b0);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000E, 16'h0010, 1'b0);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000E, 16'h0012, 1'b0);
    vecs[23] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0014, 1'b0);

    rst_n = 1'b0;
    run0 = 1'b0;
    run1 = 1'b0;
    if0.instr_ready = 1'b0;
    if0.redirect_valid = 1'b0;
    if0.redirect_target = 16'h0000;
    if1.instr_ready = 1'b0;
    if1.redirect_valid = 1'b0;
    if1.redirect_target = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {15'h0000, if0.instr_valid}, 16'h0000);
    check("reset_pc",    if0.instr_pc,   16'h0000);
    check("reset_data",  if0.instr_data, 16'h0000);
    check("reset_addr",  if0.imem_addr,  16'h0000);
    check("reset_addr1", if1.imem_addr,  16'hFFFC);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run0 = vecs[i].run;
      if0.instr_ready = vecs[i].ready;
      if0.redirect_valid = vecs[i].redir;
      if0.redirect_target = vecs[i].target;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {15'h0000, if0.instr_valid}, {15'h0000, vecs[i].exp_valid});
      check($sformatf("vec%0d_pc", i),    if0.instr_pc,   vecs[i].exp_pc);
      check($sformatf("vec%0d_data", i),  if0.instr_data, vecs[i].exp_data);
      check($sformatf("vec%0d_addr", i),  if0.imem_addr,  vecs[i].exp_addr);
      @(posedge clk);
      #1;
    end
    if0.redirect_valid = 1'b0;

    // Async reset between clock edges while instructions stream.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_pre_valid", {15'h0000, if0.instr_valid}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {15'h0000, if0.instr_valid}, 16'h0000);
    check("midrst_pc",    if0.instr_pc,  16'h0000);
    check("midrst_addr",  if0.imem_addr, 16'h0000);
    run0 = 1'b1;
    run1 = 1'b1;
    if0.instr_ready = 1'b1;
    if1.instr_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Restart from RESET_PC on both instances; dut1 wraps past 16'hFFFE.
    for (int k = 0; k < 8; k++) begin
      logic [15:0] p0;
      logic [15:0] p1;
      @(negedge clk);
      if (k < 3) begin
        check($sformatf("restart%0d_valid0", k), {15'h0000, if0.instr_valid}, 16'h0000);
        check($sformatf("restart%0d_valid1", k), {15'h0000, if1.instr_valid}, 16'h0000);
      end else begin
        p0 = 16'(2 * (k - 3));
        p1 = 16'hFFFC + 16'(2 * (k - 3));
        check($sformatf("restart%0d_valid0", k), {15'h0000, if0.instr_valid}, 16'h0001);
        check($sformatf("restart%0d_pc0", k),    if0.instr_pc,   p0);
        check($sformatf("restart%0d_data0", k),  if0.instr_data, mem_word(p0));
        check($sformatf("restart%0d_valid1", k), {15'h0000, if1.instr_valid}, 16'h0001);
        check($sformatf("restart%0d_pc1", k),    if1.instr_pc,   p1);
        check($sformatf("restart%0d_data1", k),  if1.instr_data, mem_word(p1));
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
